surf_cmd_receiver: RTL and testbench



---
 rtl/surf_cmd_receiver_pkg.sv | 42 ++++
 rtl/surf_cmd_receiver_if.sv | 22 ++
 rtl/surf_cmd_receiver_bit_sync.sv | 28 ++
 rtl/surf_cmd_receiver.sv | 182 ++++++++++++++++++
 tb/tb_surf_cmd_receiver.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/surf_cmd_receiver_pkg.sv
// Shared definitions for the SURF serial command link: state encodings, line levels and frame geometry.
// Frame geometry depends on the CMD_RX_PARITY_EN macro (parity bit present when defined).
package surf_cmd_receiver_pkg;

`ifdef CMD_RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam logic       START_BIT     = 1'b1;
    localparam logic       STOP_BIT      = 1'b0;
    localparam int         BUFFER_BITS   = 2;
    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

`ifdef CMD_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_e;
`endif

    function automatic int data_bits(input int id_width);
        return BUFFER_BITS + id_width;
    endfunction

    // Start + data + optional parity + stop.
    function automatic int frame_bits(input int id_width);
        return 1 + data_bits(id_width) + PARITY_BITS + 1;
    endfunction

endpackage

// File: rtl/surf_cmd_receiver_if.sv
// Command-line and decoded-output bundle between the CMD pin, the receiver and the SURF readout logic.
interface surf_cmd_receiver_if #(
    parameter int ID_WIDTH = 32
);
    logic                cmd_i;
    logic                digitize_o;
    logic [1:0]          buffer_o;
    logic [ID_WIDTH-1:0] event_id_o;
    logic                error_o;
    logic [7:0]          err_count_o;
    logic                busy_o;

    modport slave (
        input  cmd_i,
        output digitize_o, buffer_o, event_id_o, error_o, err_count_o, busy_o
    );

    modport master (
        output cmd_i,
        input  digitize_o, buffer_o, event_id_o, error_o, err_count_o, busy_o
    );
endinterface

// File: rtl/surf_cmd_receiver_bit_sync.sv
// cmd_bit_sync stage: 2-flop synchronizer for the asynchronous CMD line plus a previous-value
// flop, giving the synchronized level and a one-cycle rising-edge strobe.
module surf_cmd_receiver_bit_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
endmodule

// File: rtl/surf_cmd_receiver.sv
// SURF-side decoder for the TURF serial command line: recovers digitize frames (buffer + event ID),
// checks framing and, when CMD_RX_PARITY_EN is defined, even parity over the data bits.
module surf_cmd_receiver
    import surf_cmd_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int ID_WIDTH     = 32
) (
    input  logic               clk125_i,
    input  logic               rst_i,
    surf_cmd_receiver_if.slave bus_if
);
    localparam int DATA_BITS = data_bits(ID_WIDTH);
    localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W     = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic                 line_lvl;
    logic                 line_rise;
    logic                 bit_tick;
    logic                 shift_en;
    logic                 parity_good;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_ok_q;
    logic                 frame_bad_q;
    logic                 digitize_q;
    logic                 error_q;
    logic                 busy_q;
    logic [1:0]           buffer_q;
    logic [ID_WIDTH-1:0]  event_id_q;
    logic [7:0]           err_count_q;
`ifdef CMD_RX_PARITY_EN
    logic                 parity_acc_q;
    logic                 parity_bad_q;
`endif

    surf_cmd_receiver_bit_sync u_bit_sync (
        .clk_i   (clk125_i),
        .rst_i   (rst_i),
        .d_i     (bus_if.cmd_i),
        .level_o (line_lvl),
        .rise_o  (line_rise)
    );

    // Counter was reloaded at the previous sample point, so reaching 1 marks the next mid-bit.
    assign bit_tick = (cnt_q == CNT_ONE);
    assign shift_en = (state_q == ST_DATA) && bit_tick;

`ifdef CMD_RX_PARITY_EN
    assign parity_good = ~parity_bad_q;
`else
    assign parity_good = 1'b1;
`endif

    // NOTE: shift_q is pure datapath, fully refilled before it is ever loaded into the outputs,
    // so it is deliberately left out of reset.
    always_ff @(posedge clk125_i) begin
        if (shift_en) begin
            shift_q <= {shift_q[DATA_BITS-2:0], line_lvl};
        end
    end

    always_ff @(posedge clk125_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_ok_q   <= 1'b0;
            frame_bad_q  <= 1'b0;
            digitize_q   <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            buffer_q     <= '0;
            event_id_q   <= '0;
            err_count_q  <= '0;
`ifdef CMD_RX_PARITY_EN
            parity_acc_q <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low each cycle; a later non-blocking assignment in this
            // block overrides the default, which keeps every pulse exactly one cycle wide.
            digitize_q  <= 1'b0;
            error_q     <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            busy_q      <= 1'b1;

            if (frame_ok_q) begin
                digitize_q <= 1'b1;
                buffer_q   <= shift_q[DATA_BITS-1 -: BUFFER_BITS];
                event_id_q <= shift_q[ID_WIDTH-1:0];
            end
            if (frame_bad_q) begin
                error_q <= 1'b1;
                if (err_count_q != ERR_COUNT_MAX) begin
                    err_count_q <= err_count_q + 8'd1;
                end
            end

            if (state_q != ST_IDLE) begin
                cnt_q <= bit_tick ? CNT_FULL : cnt_q - CNT_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    busy_q <= line_rise;
                    if (line_rise) begin
                        state_q <= ST_START;
                        cnt_q   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        if (line_lvl == START_BIT) begin
                            state_q      <= ST_DATA;
                            idx_q        <= '0;
`ifdef CMD_RX_PARITY_EN
                            parity_acc_q <= 1'b0;
`endif
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
`ifdef CMD_RX_PARITY_EN
                        parity_acc_q <= parity_acc_q ^ line_lvl;
`endif
                        if (idx_q == IDX_LAST) begin
`ifdef CMD_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end
                end
`ifdef CMD_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        parity_bad_q <= parity_acc_q ^ line_lvl;
                        state_q      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        state_q <= ST_IDLE;
                        if ((line_lvl == STOP_BIT) && parity_good) begin
                            frame_ok_q <= 1'b1;
                        end else begin
                            frame_bad_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_if.digitize_o  = digitize_q;
    assign bus_if.buffer_o    = buffer_q;
    assign bus_if.event_id_o  = event_id_q;
    assign bus_if.error_o     = error_q;
    assign bus_if.err_count_o = err_count_q;
    assign bus_if.busy_o      = busy_q;
endmodule

// File: tb/tb_surf_cmd_receiver.sv
// Self-checking bench for surf_cmd_receiver: table of single frames plus hand-written sequences
// for glitch, stuck line, back-to-back, mid-frame reset and error-count saturation.
module tb_surf_cmd_receiver;
    localparam int CPB = 4;
    localparam int IDW = 32;
`ifdef CMD_RX_PARITY_EN
    localparam int FRAME_BITS = 37;
    localparam int LAT        = 149;
    localparam int FRAME_CYC  = 148;
`else
    localparam int FRAME_BITS = 36;
    localparam int LAT        = 145;
    localparam int FRAME_CYC  = 144;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    surf_cmd_receiver_if #(.ID_WIDTH(IDW)) dut_if ();

    surf_cmd_receiver #(
        .CLKS_PER_BIT (CPB),
        .ID_WIDTH     (IDW)
    ) dut (
        .clk125_i (clk),
        .rst_i    (rst),
        .bus_if   (dut_if)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int             dig_cyc_q[$];
    logic [1:0]     dig_buf_q[$];
    logic [IDW-1:0] dig_id_q[$];
    int             err_cyc_q[$];
    int             busy_n = 0;
    int             busy_rise = -1;
    int             busy_last = -1;
    logic           busy_prev = 1'b0;
    logic           both_seen = 1'b0;

    always @(negedge clk) begin
        if (dut_if.digitize_o === 1'b1) begin
            dig_cyc_q.push_back(cyc);
            dig_buf_q.push_back(dut_if.buffer_o);
            dig_id_q.push_back(dut_if.event_id_o);
        end
        if (dut_if.error_o === 1'b1) err_cyc_q.push_back(cyc);
        if (dut_if.digitize_o === 1'b1 && dut_if.error_o === 1'b1) both_seen = 1'b1;
        if (dut_if.busy_o === 1'b1) begin
            busy_n++;
            if (!busy_prev) busy_rise = cyc;
            busy_last = cyc;
        end
        busy_prev = (dut_if.busy_o === 1'b1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        dig_cyc_q.delete();
        dig_buf_q.delete();
        dig_id_q.delete();
        err_cyc_q.delete();
        busy_n    = 0;
        busy_rise = -1;
        busy_last = -1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives the first nbits bits of a frame, CPB cycles each; leaves cmd_i at the last bit.
    task automatic drive_frame(input logic [1:0] b, input logic [IDW-1:0] id, input logic stop_v,
                               input logic flip, input int nbits, output int t0);
        logic par;
        par = (^{b, id}) ^ flip;
        t0  = cyc + 1;
        for (int k = 0; k < nbits && k < FRAME_BITS; k++) begin
            logic v;
            if (k == 0)                   v = 1'b1;
            else if (k <= 2)              v = b[2 - k];
            else if (k <= 2 + IDW)        v = id[IDW + 2 - k];
            else if (k == FRAME_BITS - 1) v = stop_v;
            else                          v = par;
            dut_if.cmd_i = v;
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0]     buffer;
        logic [IDW-1:0] id;
        logic           stop_v;
        logic           flip;
        logic           exp_dig;
        logic [1:0]     exp_buf;
        logic [IDW-1:0] exp_id;
        logic [7:0]     exp_errc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int got;

        vecs[0] = '{2'd2, 32'h0012_3456, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0012_3456, 8'd0};
        vecs[1] = '{2'd2, 32'h0012_3456, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0012_3456, 8'd1};
`ifdef CMD_RX_PARITY_EN
        vecs[2] = '{2'd1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0012_3456, 8'd2};
        vecs[3] = '{2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 8'd2};
        vecs[4] = '{2'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 8'd2};
        vecs[5] = '{2'd3, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 2'd3, 32'h8000_0001, 8'd2};
`else
        vecs[2] = '{2'd1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 2'd1, 32'hDEAD_BEEF, 8'd1};
        vecs[3] = '{2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 8'd1};
        vecs[4] = '{2'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 8'd1};
        vecs[5] = '{2'd3, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 2'd3, 32'h8000_0001, 8'd1};
`endif

        rst = 1'b1;
        dut_if.cmd_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digitize",  dut_if.digitize_o,  0);
        check("reset_buffer",    dut_if.buffer_o,    0);
        check("reset_event_id",  dut_if.event_id_o,  0);
        check("reset_error",     dut_if.error_o,     0);
        check("reset_err_count", dut_if.err_count_o, 0);
        check("reset_busy",      dut_if.busy_o,      0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single frames from the table.
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            drive_frame(vecs[i].buffer, vecs[i].id, vecs[i].stop_v, vecs[i].flip, FRAME_BITS, t0);
            dut_if.cmd_i = 1'b0;
            wait_until(t0 + LAT + 4);
            got = -1;
            if (vecs[i].exp_dig && dig_cyc_q.size() > 0) got = dig_cyc_q[0];
            if (!vecs[i].exp_dig && err_cyc_q.size() > 0) got = err_cyc_q[0];
            check($sformatf("vec%0d_digitize_pulses", i), dig_cyc_q.size(), {63'd0, vecs[i].exp_dig});
            check($sformatf("vec%0d_error_pulses", i), err_cyc_q.size(), {63'd0, ~vecs[i].exp_dig});
            check($sformatf("vec%0d_strobe_cycle", i), got, t0 + LAT);
            check($sformatf("vec%0d_buffer", i), dut_if.buffer_o, vecs[i].exp_buf);
            check($sformatf("vec%0d_event_id", i), dut_if.event_id_o, vecs[i].exp_id);
            check($sformatf("vec%0d_err_count", i), dut_if.err_count_o, vecs[i].exp_errc);
            if (i == 0) begin
                check("vec0_busy_first_cycle", busy_rise, t0 + 2);
                check("vec0_busy_last_cycle",  busy_last, t0 + LAT - 1);
            end
        end

        // One-cycle glitch: brief busy, no strobes, no count.
        clear_mon();
        t0 = cyc + 1;
        dut_if.cmd_i = 1'b1;
        @(posedge clk);
        #1;
        dut_if.cmd_i = 1'b0;
        wait_until(t0 + 40);
        check("glitch_busy_cycles", busy_n, 3);
        check("glitch_strobes", dig_cyc_q.size() + err_cyc_q.size(), 0);
        check("glitch_err_count", dut_if.err_count_o, vecs[5].exp_errc);

        // Stuck-high line after a failed stop: a single error, then silence.
        clear_mon();
        drive_frame(2'd1, 32'h0000_00AA, 1'b1, 1'b0, FRAME_BITS, t0);
        wait_until(t0 + LAT + 300);
        check("stuck_error_pulses", err_cyc_q.size(), 1);
        check("stuck_digitize_pulses", dig_cyc_q.size(), 0);
        got = (err_cyc_q.size() > 0) ? err_cyc_q[0] : -1;
        check("stuck_error_cycle", got, t0 + LAT);
        dut_if.cmd_i = 1'b0;
        wait_until(cyc + 20);
        check("stuck_no_more_errors", err_cyc_q.size(), 1);
        check("stuck_err_count", dut_if.err_count_o, vecs[5].exp_errc + 8'd1);

        // Back-to-back frames with no idle gap.
        clear_mon();
        drive_frame(2'd0, 32'h0000_0001, 1'b0, 1'b0, FRAME_BITS, t0);
        drive_frame(2'd3, 32'h0000_0002, 1'b0, 1'b0, FRAME_BITS, t1);
        dut_if.cmd_i = 1'b0;
        wait_until(t1 + LAT + 4);
        check("b2b_pulses", dig_cyc_q.size(), 2);
        if (dig_cyc_q.size() == 2) begin
            check("b2b_spacing", dig_cyc_q[1] - dig_cyc_q[0], FRAME_CYC);
            check("b2b_first_cycle", dig_cyc_q[0], t0 + LAT);
            check("b2b_first_buffer", dig_buf_q[0], 2'd0);
            check("b2b_first_id", dig_id_q[0], 32'h0000_0001);
            check("b2b_second_buffer", dig_buf_q[1], 2'd3);
            check("b2b_second_id", dig_id_q[1], 32'h0000_0002);
        end

        // Reset in the middle of bit 20.
        clear_mon();
        drive_frame(2'd2, 32'h0F0F_0F0F, 1'b0, 1'b0, 21, t0);
        rst = 1'b1;
        dut_if.cmd_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_digitize",  dut_if.digitize_o,  0);
        check("midrst_buffer",    dut_if.buffer_o,    0);
        check("midrst_event_id",  dut_if.event_id_o,  0);
        check("midrst_error",     dut_if.error_o,     0);
        check("midrst_err_count", dut_if.err_count_o, 0);
        check("midrst_busy",      dut_if.busy_o,      0);
        rst = 1'b0;
        wait_until(cyc + 200);
        check("midrst_no_strobes", dig_cyc_q.size() + err_cyc_q.size(), 0);

        clear_mon();
        drive_frame(2'd3, 32'hCAFE_F00D, 1'b0, 1'b0, FRAME_BITS, t0);
        dut_if.cmd_i = 1'b0;
        wait_until(t0 + LAT + 4);
        got = (dig_cyc_q.size() > 0) ? dig_cyc_q[0] : -1;
        check("postrst_digitize_cycle", got, t0 + LAT);
        check("postrst_buffer", dut_if.buffer_o, 2'd3);
        check("postrst_event_id", dut_if.event_id_o, 32'hCAFE_F00D);

        // 300 bad frames: counter saturates at 255 while error_o keeps pulsing.
        clear_mon();
        for (int n = 0; n < 300; n++) begin
            drive_frame(2'd1, 32'h1234_5678, 1'b1, 1'b0, FRAME_BITS, t0);
            dut_if.cmd_i = 1'b0;
            wait_until(cyc + 8);
            if (n == 253) begin
                wait_until(t0 + LAT + 2);
                check("sat_count_at_254", dut_if.err_count_o, 8'd254);
            end
        end
        wait_until(t0 + LAT + 4);
        check("sat_error_pulses", err_cyc_q.size(), 300);
        check("sat_digitize_pulses", dig_cyc_q.size(), 0);
        check("sat_err_count", dut_if.err_count_o, 8'd255);
        check("sat_buffer_held", dut_if.buffer_o, 2'd3);

        check("no_simultaneous_strobes", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
